if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined RV32I core, directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives a req/ack instruction-memory port.
- Registers each fetched word with its PC and PC+4, and holds them steady under stall.
- Squashes in-flight and buffered fetches on a branch/jump redirect, presenting a NOP to IF/ID.

---
 rtl/if_fetch_stage_if.sv | 22 ++
 rtl/if_fetch_stage.sv | 176 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/ack port between the fetch stage and imem.
// master = fetch side, slave = memory side.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: fetch PC, req/ack imem port, 1-entry skid,
// redirect squash. Optional misaligned-target trap: IF_MISALIGN_CHK_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    if_fetch_stage_if.master        imem,
    output logic                    if_valid,
    output logic [31:0]             if_inst,
    output logic [31:0]             if_pc_out,
    output logic [31:0]             if_pc_addr0,
    output logic                    if_misaligned
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DISCARD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q;
    logic        misal_q, misal_d;

    logic        slot_v_q, slot_v_d;
    logic [31:0] slot_inst_q, slot_inst_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_pc4_q, slot_pc4_d;

    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic [31:0] tgt_pc;
    logic        tgt_misal;
    logic [31:0] pc_inc;
    logic        ack_ok;

`ifdef IF_MISALIGN_CHK_EN
    assign tgt_pc    = redirect_pc;
    assign tgt_misal = |redirect_pc[1:0];
`else
    assign tgt_pc    = redirect_pc & ~32'h3;
    assign tgt_misal = 1'b0;
`endif

    // DISCARD keeps the old address on the bus until its ack arrives.
    assign imem.imem_req  = rst_n & ((state_q == ST_DISCARD) |
                            ((state_q == ST_REQ) & ~misal_q));
    assign imem.imem_addr = (state_q == ST_DISCARD) ? addr_q : fetch_pc_q;

    assign pc_inc = fetch_pc_q + 32'd4;
    assign ack_ok = (state_q == ST_REQ) & ~misal_q & imem.imem_ack;

    assign if_valid    = slot_v_q;
    assign if_inst     = slot_inst_q;
    assign if_pc_out   = slot_pc_q;
    assign if_pc_addr0 = slot_pc4_q;
    assign if_misaligned = misal_q;

    // Next state: redirect flush first, else drain slot then place any ack.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        misal_d     = misal_q;
        slot_v_d    = slot_v_q;
        slot_inst_d = slot_inst_q;
        slot_pc_d   = slot_pc_q;
        slot_pc4_d  = slot_pc4_q;
        skid_v_d    = skid_v_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        if (redirect_valid) begin
            fetch_pc_d  = tgt_pc;
            misal_d     = tgt_misal;
            slot_v_d    = tgt_misal;
            slot_inst_d = NOP_INST;
            skid_v_d    = 1'b0;
            if (tgt_misal) begin
                slot_pc_d  = tgt_pc;
                slot_pc4_d = tgt_pc + 32'd4;
            end
            if (imem.imem_req && !imem.imem_ack) begin
                state_d = ST_DISCARD;
            end else begin
                state_d = ST_REQ;
            end
        end else if (misal_q) begin
            if (state_q == ST_DISCARD && imem.imem_ack) begin
                state_d = ST_REQ;
            end
        end else begin
            if (slot_v_q && !stall) begin
                if (skid_v_q) begin
                    slot_inst_d = skid_inst_q;
                    slot_pc_d   = skid_pc_q;
                    slot_pc4_d  = skid_pc_q + 32'd4;
                    skid_v_d    = 1'b0;
                end else begin
                    slot_v_d    = 1'b0;
                    slot_inst_d = NOP_INST;
                end
            end
            if (ack_ok) begin
                fetch_pc_d = pc_inc;
                if (!slot_v_d) begin
                    slot_v_d    = 1'b1;
                    slot_inst_d = imem.imem_rdata;
                    slot_pc_d   = fetch_pc_q;
                    slot_pc4_d  = pc_inc;
                end else begin
                    skid_v_d    = 1'b1;
                    skid_inst_d = imem.imem_rdata;
                    skid_pc_d   = fetch_pc_q;
                end
            end
            unique case (state_q)
                ST_REQ: begin
                    if (ack_ok && slot_v_d && skid_v_d) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!stall) begin
                        state_d = ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (imem.imem_ack) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // Stage registers and the latched address of a request being discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            fetch_pc_q  <= RESET_PC;
            addr_q      <= RESET_PC;
            misal_q     <= 1'b0;
            slot_v_q    <= 1'b0;
            slot_inst_q <= NOP_INST;
            slot_pc_q   <= RESET_PC;
            slot_pc4_q  <= RESET_PC + 32'd4;
            skid_v_q    <= 1'b0;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            if (state_q != ST_DISCARD) begin
                addr_q <= fetch_pc_q;
            end
            misal_q     <= misal_d;
            slot_v_q    <= slot_v_d;
            slot_inst_q <= slot_inst_d;
            slot_pc_q   <= slot_pc_d;
            slot_pc4_q  <= slot_pc4_d;
            skid_v_q    <= skid_v_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: imem responder with
// programmable latency plus an in-order scoreboard of fetched words.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc_out;
    logic [31:0] if_pc_addr0;
    logic        if_misaligned;

    if_fetch_stage_if imem ();

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc_out      (if_pc_out),
        .if_pc_addr0    (if_pc_addr0),
        .if_misaligned  (if_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    bit   discard = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mem_lat = 0;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[17:2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic mem_proc();
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!imem.imem_req) begin
                imem.imem_ack = 1'b0;
                cnt = 0;
            end else if (cnt >= mem_lat) begin
                imem.imem_ack = 1'b1;
                imem.imem_rdata = inst_of(imem.imem_addr);
                cnt = 0;
            end else begin
                imem.imem_ack = 1'b0;
                cnt++;
            end
        end
    endtask

    task automatic monitor();
        logic        held = 1'b0;
        logic [31:0] held_addr = 32'h0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                n_cmp++;
                if (imem.imem_req !== 1'b1 || imem.imem_addr !== held_addr) begin
                    n_err++;
                    $display("FAIL addr_stable: req=%b addr=%h required req=1 addr=%h",
                             imem.imem_req, imem.imem_addr, held_addr);
                end
            end
            held = imem.imem_req && !imem.imem_ack;
            held_addr = imem.imem_addr;
            if (redirect_valid) begin
                exp_q.delete();
                discard = imem.imem_req && !imem.imem_ack;
            end else begin
                if (if_valid && !stall && !if_misaligned) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_extra: pc=%h inst=%h required no output",
                                 if_pc_out, if_inst);
                    end else begin
                        e = exp_q.pop_front();
                        if (if_pc_out !== e.pc || if_inst !== e.inst ||
                            if_pc_addr0 !== e.pc + 32'd4) begin
                            n_err++;
                            $display("FAIL sb_data: pc=%h inst=%h pc4=%h required %h %h %h",
                                     if_pc_out, if_inst, if_pc_addr0,
                                     e.pc, e.inst, e.pc + 32'd4);
                        end
                    end
                end
                if (imem.imem_req && imem.imem_ack) begin
                    if (discard) begin
                        discard = 1'b0;
                    end else begin
                        exp_q.push_back('{pc: imem.imem_addr, inst: imem.imem_rdata});
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) smp();
        n_cmp++;
        if (imem.imem_req !== 1'b0) begin
            n_err++; $display("FAIL rst_req: got %b required 0", imem.imem_req);
        end
        n_cmp++;
        if (if_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_valid: got %b required 0", if_valid);
        end
        n_cmp++;
        if (if_inst !== NOP) begin
            n_err++; $display("FAIL rst_inst: got %h required %h", if_inst, NOP);
        end
        n_cmp++;
        if (if_pc_out !== 32'h0 || if_pc_addr0 !== 32'h4) begin
            n_err++;
            $display("FAIL rst_pc: got %h/%h required 0/4", if_pc_out, if_pc_addr0);
        end
        n_cmp++;
        if (if_misaligned !== 1'b0) begin
            n_err++; $display("FAIL rst_misal: got %b required 0", if_misaligned);
        end
    endtask

    task automatic test_stream();
        mem_lat = 0;
        @(negedge clk);
        rst_n = 1'b1;
        smp();
        n_cmp++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0 ||
            imem.imem_ack !== 1'b1 || if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL first_req: req=%b addr=%h ack=%b valid=%b required 1 0 1 0",
                     imem.imem_req, imem.imem_addr, imem.imem_ack, if_valid);
        end
        for (int i = 0; i < 6; i++) begin
            smp();
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc_out !== 32'(4 * i) ||
                if_pc_addr0 !== 32'(4 * i + 4)) begin
                n_err++;
                $display("FAIL stream_%0d: valid=%b pc=%h pc4=%h required 1 %h %h",
                         i, if_valid, if_pc_out, if_pc_addr0, 4 * i, 4 * i + 4);
            end
        end
    endtask

    task automatic test_latency();
        bit found = 1'b0;
        int nval = 0;
        mem_lat = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            smp();
            found = (imem.imem_ack === 1'b1);
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++; $display("FAIL lat_sync: no ack seen, required ack");
        end
        for (int k = 1; k <= 16; k++) begin
            smp();
            if (if_valid === 1'b1) nval++;
            if (k == 2) begin
                n_cmp++;
                if (if_valid !== 1'b0) begin
                    n_err++; $display("FAIL lat_gap: valid=%b required 0", if_valid);
                end
            end
        end
        n_cmp++;
        if (nval != 4) begin
            n_err++; $display("FAIL lat_rate: got %0d valid required 4", nval);
        end
    endtask

    task automatic test_stall_skid();
        bit found = 1'b0;
        logic [31:0] p;
        mem_lat = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            smp();
            found = (if_valid === 1'b1 && imem.imem_ack === 1'b1);
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++; $display("FAIL stall_sync: stream not seen, required stream");
        end
        tick();
        stall = 1'b1;
        smp();
        p = exp_q[0].pc;
        n_cmp++;
        if (if_valid !== 1'b1 || imem.imem_ack !== 1'b1) begin
            n_err++;
            $display("FAIL stall_setup: valid=%b ack=%b required 1 1", if_valid, imem.imem_ack);
        end
        for (int i = 0; i < 4; i++) begin
            smp();
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc_out !== p || if_inst !== inst_of(p) ||
                imem.imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold_%0d: valid=%b pc=%h inst=%h req=%b required 1 %h %h 0",
                         i, if_valid, if_pc_out, if_inst, imem.imem_req, p, inst_of(p));
            end
        end
        tick();
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) smp();
            else @(negedge clk);
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc_out !== p + 32'(4 * i)) begin
                n_err++;
                $display("FAIL stall_release_%0d: valid=%b pc=%h required 1 %h",
                         i, if_valid, if_pc_out, p + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_discard();
        bit found = 1'b0;
        bit leak = 1'b0;
        mem_lat = 2;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            smp();
            found = (imem.imem_req === 1'b1 && imem.imem_addr === 32'h20 &&
                     imem.imem_ack === 1'b0);
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++; $display("FAIL redir_sync: no req to 00000020, required req");
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (if_valid !== 1'b0 || if_inst !== NOP || imem.imem_addr !== 32'h20) begin
            n_err++;
            $display("FAIL redir_flush: valid=%b inst=%h addr=%h required 0 %h 00000020",
                     if_valid, if_inst, imem.imem_addr, NOP);
        end
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            smp();
            if (if_valid !== 1'b0) leak = 1'b1;
            found = (imem.imem_req === 1'b1 && imem.imem_addr === 32'h100);
        end
        n_cmp++;
        if (found !== 1'b1 || leak !== 1'b0) begin
            n_err++;
            $display("FAIL redir_target: found=%b leak=%b required 1 0", found, leak);
        end
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            smp();
            found = (if_valid === 1'b1);
        end
        n_cmp++;
        if (found !== 1'b1 || if_pc_out !== 32'h100 || if_inst !== inst_of(32'h100)) begin
            n_err++;
            $display("FAIL redir_first: valid=%b pc=%h inst=%h required 1 00000100 %h",
                     if_valid, if_pc_out, if_inst, inst_of(32'h100));
        end
    endtask

    task automatic test_redirect_stall();
        bit found = 1'b0;
        mem_lat = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            smp();
            found = (if_valid === 1'b1 && imem.imem_ack === 1'b1);
        end
        tick();
        stall = 1'b1;
        tick();
        smp();
        n_cmp++;
        if (found !== 1'b1 || imem.imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rs_setup: found=%b req=%b required 1 0", found, imem.imem_req);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (if_valid !== 1'b0 || if_inst !== NOP || imem.imem_req !== 1'b1 ||
            imem.imem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL rs_flush: valid=%b inst=%h req=%b addr=%h required 0 %h 1 00000200",
                     if_valid, if_inst, imem.imem_req, imem.imem_addr, NOP);
        end
        smp();
        tick();
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) smp();
            else @(negedge clk);
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc_out !== 32'h200 + 32'(4 * i)) begin
                n_err++;
                $display("FAIL rs_resume_%0d: valid=%b pc=%h required 1 %h",
                         i, if_valid, if_pc_out, 32'h200 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_wrap();
        bit found = 1'b0;
        mem_lat = 0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            smp();
            found = (if_valid === 1'b1);
        end
        n_cmp++;
        if (found !== 1'b1 || if_pc_out !== 32'hFFFF_FFF8) begin
            n_err++;
            $display("FAIL wrap_first: valid=%b pc=%h required 1 fffffff8", if_valid, if_pc_out);
        end
        smp();
        n_cmp++;
        if (if_pc_out !== 32'hFFFF_FFFC || if_pc_addr0 !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_top: pc=%h pc4=%h required fffffffc 00000000",
                     if_pc_out, if_pc_addr0);
        end
        smp();
        n_cmp++;
        if (if_pc_out !== 32'h0 || if_pc_addr0 !== 32'h4) begin
            n_err++;
            $display("FAIL wrap_zero: pc=%h pc4=%h required 0 4", if_pc_out, if_pc_addr0);
        end
    endtask

    task automatic test_misalign();
        bit found = 1'b0;
        mem_lat = 0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        #1;
`ifdef IF_MISALIGN_CHK_EN
        n_cmp++;
        if (if_misaligned !== 1'b1 || if_valid !== 1'b1 || if_pc_out !== 32'h102 ||
            if_inst !== NOP || imem.imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL misal_trap: mis=%b valid=%b pc=%h inst=%h req=%b required 1 1 00000102 %h 0",
                     if_misaligned, if_valid, if_pc_out, if_inst, imem.imem_req, NOP);
        end
        for (int i = 0; i < 3; i++) begin
            smp();
            n_cmp++;
            if (if_misaligned !== 1'b1 || imem.imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL misal_hold_%0d: mis=%b req=%b required 1 0",
                         i, if_misaligned, imem.imem_req);
            end
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            smp();
            found = (if_valid === 1'b1);
        end
        n_cmp++;
        if (found !== 1'b1 || if_pc_out !== 32'h300 || if_misaligned !== 1'b0) begin
            n_err++;
            $display("FAIL misal_recover: valid=%b pc=%h mis=%b required 1 00000300 0",
                     if_valid, if_pc_out, if_misaligned);
        end
`else
        n_cmp++;
        if (if_misaligned !== 1'b0 || imem.imem_req !== 1'b1 ||
            imem.imem_addr !== 32'h100) begin
            n_err++;
            $display("FAIL misal_mask: mis=%b req=%b addr=%h required 0 1 00000100",
                     if_misaligned, imem.imem_req, imem.imem_addr);
        end
        for (int i = 0; i < 10 && !found; i++) begin
            smp();
            found = (if_valid === 1'b1);
        end
        n_cmp++;
        if (found !== 1'b1 || if_pc_out !== 32'h100) begin
            n_err++;
            $display("FAIL misal_fetch: valid=%b pc=%h required 1 00000100", if_valid, if_pc_out);
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        imem.imem_ack = 1'b0;
        imem.imem_rdata = 32'h0;
        fork
            mem_proc();
            monitor();
        join_none
        test_reset();
        test_stream();
        test_latency();
        test_stall_skid();
        test_redirect_discard();
        test_redirect_stall();
        test_wrap();
        test_misalign();
        repeat (4) smp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
